// File: rtl/div_unit_pkg.sv
// Shared definitions for the RV32M iterative divider: funct3 codes,
// FSM state encoding and small two's-complement helpers.
package div_unit_pkg;

   localparam int XLEN = 32;

   // RV32M divide-class funct3 encodings
   localparam logic [2:0] FUNCT3_DIV  = 3'b100;
   localparam logic [2:0] FUNCT3_DIVU = 3'b101;
   localparam logic [2:0] FUNCT3_REM  = 3'b110;
   localparam logic [2:0] FUNCT3_REMU = 3'b111;

   // Last restoring step index (32 steps: 0..31)
   localparam logic [4:0] LAST_STEP = 5'd31;

   typedef enum logic [1:0] {
      ST_IDLE = 2'b00,
      ST_CALC = 2'b01,
      ST_DONE = 2'b10
   } div_state_e;

   // Two's-complement negation
   function automatic logic [31:0] twos_neg(input logic [31:0] value);
      return ~value + 32'd1;
   endfunction

   // Absolute value for signed operands, pass-through otherwise
   function automatic logic [31:0] magnitude(input logic [31:0] value, input logic is_signed);
      return (is_signed && value[31]) ? twos_neg(value) : value;
   endfunction

endpackage

// File: rtl/div_unit.sv
// RV32M divide unit: 32-step radix-2 restoring divider on operand
// magnitudes with sign fix-up, divide-by-zero and signed-overflow bypass,
// pipeline flush and a registered register-file write-back port.
module div_unit
   import div_unit_pkg::*;
(
   input  logic        ip_clk,
   input  logic        ip_rst,
   input  logic        ip_start,
   input  logic        ip_flush,
   input  logic [2:0]  ip_funct3,
   input  logic [31:0] ip_rs1,
   input  logic [31:0] ip_rs2,
   input  logic [4:0]  ip_rd_addr,
   output logic        op_busy,
   output logic        op_done,
   output logic        op_wr_en,
   output logic [4:0]  op_rd_addr,
   output logic [31:0] op_result
);

   div_state_e  state;
   div_state_e  next_state;

   // Captured operation context
   logic [31:0] quo;        // dividend magnitude shifting out, quotient shifting in
   logic [31:0] rem_acc;    // partial remainder
   logic [31:0] dsr;        // divisor magnitude
   logic [4:0]  count;
   logic        op_is_rem;
   logic        neg_q;
   logic        neg_r;
   logic [4:0]  rd_reg;

   // Request decode on the raw inputs
   logic        in_signed;
   logic        in_is_rem;
   logic        div_zero;
   logic        ovf;
   logic        start_ok;
   logic [31:0] bypass_result;

   // FSM controls
   logic        load_op;
   logic        bypass;
   logic        calc_step;
   logic [4:0]  done_rd;

   // Restoring step datapath
   logic [32:0] partial;
   logic        step_ok;
   logic [31:0] sub;
   logic [31:0] step_rem;
   logic [31:0] step_quo;
   logic [31:0] q_fin;
   logic [31:0] r_fin;
   logic [31:0] final_result;

   assign in_signed = (ip_funct3 == FUNCT3_DIV) || (ip_funct3 == FUNCT3_REM);
   assign in_is_rem = (ip_funct3 == FUNCT3_REM) || (ip_funct3 == FUNCT3_REMU);
   assign div_zero  = (ip_rs2 == 32'd0);
   assign ovf       = in_signed && (ip_rs1 == 32'h8000_0000) && (ip_rs2 == 32'hFFFF_FFFF);
   // A kill in the same cycle as a request wins: nothing is captured
   assign start_ok  = ip_start && ip_funct3[2] && !ip_flush;

   // Architectural results for the cases that skip the iteration
   always_comb begin
      bypass_result = 32'd0;
      if (div_zero) begin
         bypass_result = in_is_rem ? ip_rs1 : 32'hFFFF_FFFF;
      end else if (in_is_rem) begin
         bypass_result = 32'd0;
      end else begin
         bypass_result = 32'h8000_0000;
      end
   end

   // One restoring step: shift in next dividend bit, subtract if it fits
   always_comb begin
      partial  = {rem_acc, quo[31]};
      step_ok  = (partial >= {1'b0, dsr});
      // When the subtraction is taken the true difference fits in 32 bits
      sub      = partial[31:0] - dsr;
      step_rem = step_ok ? sub : partial[31:0];
      step_quo = {quo[30:0], step_ok};
      q_fin    = neg_q ? twos_neg(step_quo) : step_quo;
      r_fin    = neg_r ? twos_neg(step_rem) : step_rem;
      final_result = op_is_rem ? r_fin : q_fin;
   end

   // State register
   always_ff @(posedge ip_clk or posedge ip_rst) begin
      if (ip_rst) begin
         state <= ST_IDLE;
      end else begin
         state <= next_state;
      end
   end

   // Next-state logic and per-cycle datapath controls
   always_comb begin
      next_state = state;
      load_op    = 1'b0;
      bypass     = 1'b0;
      calc_step  = 1'b0;
      case (state)
         ST_IDLE: begin
            if (start_ok) begin
               load_op = 1'b1;
               if (div_zero || ovf) begin
                  bypass     = 1'b1;
                  next_state = ST_DONE;
               end else begin
                  next_state = ST_CALC;
               end
            end else begin
               next_state = ST_IDLE;
            end
         end
         ST_CALC: begin
            if (ip_flush) begin
               next_state = ST_IDLE;
            end else if (count == LAST_STEP) begin
               calc_step  = 1'b1;
               next_state = ST_DONE;
            end else begin
               calc_step  = 1'b1;
               next_state = ST_CALC;
            end
         end
         ST_DONE: begin
            next_state = ST_IDLE;
         end
         default: begin
            next_state = ST_IDLE;
         end
      endcase
   end

   assign done_rd = bypass ? ip_rd_addr : rd_reg;

   // Operand capture and iterative restoring division
   always_ff @(posedge ip_clk or posedge ip_rst) begin
      if (ip_rst) begin
         quo       <= 32'd0;
         rem_acc   <= 32'd0;
         dsr       <= 32'd0;
         count     <= 5'd0;
         op_is_rem <= 1'b0;
         neg_q     <= 1'b0;
         neg_r     <= 1'b0;
         rd_reg    <= 5'd0;
      end else if (load_op) begin
         quo       <= magnitude(ip_rs1, in_signed);
         rem_acc   <= 32'd0;
         dsr       <= magnitude(ip_rs2, in_signed);
         count     <= 5'd0;
         op_is_rem <= in_is_rem;
         neg_q     <= in_signed && (ip_rs1[31] ^ ip_rs2[31]);
         neg_r     <= in_signed && ip_rs1[31];
         rd_reg    <= ip_rd_addr;
      end else if (calc_step) begin
         quo       <= step_quo;
         rem_acc   <= step_rem;
         count     <= count + 5'd1;
      end
   end

   // Registered status and write-back outputs, result held between completions
   always_ff @(posedge ip_clk or posedge ip_rst) begin
      if (ip_rst) begin
         op_busy    <= 1'b0;
         op_done    <= 1'b0;
         op_wr_en   <= 1'b0;
         op_rd_addr <= 5'd0;
         op_result  <= 32'd0;
      end else begin
         op_busy <= (next_state != ST_IDLE);
         op_done <= (next_state == ST_DONE);
         if (next_state == ST_DONE) begin
            op_wr_en   <= (done_rd != 5'd0);
            op_rd_addr <= done_rd;
            op_result  <= bypass ? bypass_result : final_result;
         end else begin
            op_wr_en   <= 1'b0;
         end
      end
   end

endmodule

// File: doc/div_unit.md
DIV_UNIT -- requirements
Module: div_unit

Interface
REQ-001 SHALL have no parameters; width fixed at 32 bits (RV32M).
REQ-002 SHALL have one clock; reset is asynchronous and active-high; ports ip_clk and ip_rst.
REQ-003 ip_clk  input  1  rising-edge clock.
REQ-004 ip_rst  input  1  asynchronous active-high reset.
REQ-005 ip_start  input  1  request a divide; sampled only in IDLE.
REQ-006 ip_flush  input  1  abort in-flight divide (pipeline kill).
REQ-007 ip_funct3  input  3  100 DIV, 101 DIVU, 110 REM, 111 REMU.
REQ-008 ip_rs1  input  32  dividend (register-file rs1 read port).
REQ-009 ip_rs2  input  32  divisor (register-file rs2 read port).
REQ-010 ip_rd_addr  input  5  destination register index.
REQ-011 op_busy  output  1  high in CALC and DONE.
REQ-012 op_done  output  1  one-cycle result-valid pulse.
REQ-013 op_wr_en  output  1  register-file write enable (write-back port).
REQ-014 op_rd_addr  output  5  captured destination index.
REQ-015 op_result  output  32  quotient or remainder (register-file write data).

Function
REQ-016 SHALL implement states IDLE, CALC, DONE.
REQ-017 IDLE: ip_start=1 with ip_funct3[2]=1 SHALL capture operands, funct3 and rd_addr, then go to CALC; ip_start with ip_funct3[2]=0 SHALL be ignored.
REQ-018 CALC SHALL perform one radix-2 restoring step per cycle on magnitudes, 32 steps, counter 0..31, then go to DONE.
REQ-019 Normal latency: start sampled in cycle 0 -> op_done high in cycle 33.
REQ-020 Divisor zero SHALL bypass CALC (IDLE -> DONE, op_done in cycle 1): DIV/DIVU result 0xFFFFFFFF, REM/REMU result = dividend.
REQ-021 DIV/REM with dividend 0x80000000 and divisor 0xFFFFFFFF SHALL bypass CALC: DIV result 0x80000000, REM result 0.
REQ-022 Signed ops: quotient negated when operand signs differ; remainder takes dividend sign; no sign correction for DIVU/REMU.
REQ-023 DONE SHALL last exactly one cycle with op_done=1, then return to IDLE; new start accepted in the following IDLE cycle.
REQ-024 op_wr_en SHALL equal op_done AND (op_rd_addr != 0); x0 never written.
REQ-025 op_result and op_rd_addr SHALL be registered and hold their value until the next DONE.
REQ-026 ip_start while op_busy=1 SHALL be ignored; captured operands unchanged.
REQ-027 ip_flush=1 in CALC or DONE SHALL return to IDLE at the next edge with op_done, op_wr_en low in that and all following cycles until a new op completes; op_result unchanged.
REQ-028 ip_flush and ip_start both high in IDLE: flush wins, nothing captured.

Reset
REQ-029 ip_rst=1 SHALL asynchronously force IDLE, counter 0, op_busy 0, op_done 0, op_wr_en 0, op_rd_addr 0, op_result 0.
REQ-030 Reset mid-CALC SHALL discard the operation; no op_done after reset release.
REQ-031 First start SHALL be accepted on the first rising edge with ip_rst low.

Structure
REQ-032 Shared package SHALL hold funct3 constants (DIV, DIVU, REM, REMU) and the state encoding.
REQ-033 No sub-module; one restoring-step subtractor inline.

Verification
REQ-034 DIVU 100/7, rd=5 -> op_done cycle 33, op_result 14, op_wr_en=1, op_rd_addr=5; REMU same operands -> 2.
REQ-035 DIV 0xFFFFFFF9 (-7) / 2 -> 0xFFFFFFFD; REM -> 0xFFFFFFFF; DIV 7 / 0xFFFFFFFE (-2) -> 0xFFFFFFFD.
REQ-036 DIVU 0x12345678/0 -> 0xFFFFFFFF in cycle 1; REMU -> 0x12345678 in cycle 1.
REQ-037 DIV 0x80000000/0xFFFFFFFF -> 0x80000000 in cycle 1; REM -> 0; rd=0 -> op_done=1, op_wr_en=0.
REQ-038 Start, second start at cycle 5 (ignored), flush at cycle 10 -> op_busy low from cycle 11, no op_done; ip_rst pulse at cycle 20 of a new op -> no op_done, all outputs 0.
